// File: rtl/shared_and_arb.sv
// Round-robin arbiter that time-shares one W-bit AND unit among N requesters.
// Each operation runs IDLE -> EXEC -> DONE; results come back tagged with the channel index.
module shared_and_arb #(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 8,
    parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   op_a,
    input  logic [N*W-1:0]   op_b,
    output logic [N-1:0]     gnt,
    output logic [W-1:0]     res,
    output logic             res_valid,
    output logic [IDW-1:0]   res_id,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   res_q, res_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           res_valid_q, res_valid_d;

    logic           found;
    logic [IDW-1:0] sel;
    int unsigned    idx;
    logic [W-1:0]   and_out;

    // The single shared datapath unit, fed only from the captured operands.
    assign and_out = a_q & b_q;

    // First requester at or after ptr, wrapping at N so indices >= N never appear.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = off + 32'(ptr_q);
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx[IDW-1:0]]) begin
                found = 1'b1;
                sel   = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        res_id_d    = res_id_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        gnt_d       = gnt_q;
        res_valid_d = res_valid_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                    a_d        = op_a[sel*W +: W];
                    b_d        = op_b[sel*W +: W];
                    id_d       = sel;
                    state_d    = StExec;
                end
            end
            StExec: begin
                gnt_d       = '0;
                res_d       = and_out;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                // Just-served channel drops to lowest priority next round.
                ptr_d       = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                res_valid_d = 1'b0;
                state_d     = StIdle;
            end
            default: begin
                gnt_d       = '0;
                res_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            id_q        <= '0;
            res_id_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            res_id_q    <= res_id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != StIdle);

endmodule
